alu_issue: RTL

Execute-stage issue/hold unit placed directly upstream of the combinational ALU. It accepts one decoded operation per valid/ready handshake and latches the operands and the 3-bit operation select. It holds them stable on the ALU inputs for a fixed multicycle window: 1 cycle for simple ops, longer for multiply and divide. It then captures the ALU's R/ZF into a registered result that is presented downstream with valid/ready.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_issue.sv | 76 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU select encodings and issue-unit state encoding shared by the execute stage
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_MUL   = 3'd5;
    localparam logic [2:0] ALU_DIV   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream op handshake, ALU operand/result wiring and downstream result handshake
interface alu_issue_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_sel;
    logic [4:0]  in_rd;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  SEL;
    logic [31:0] R;
    logic        ZF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zf;
    logic [4:0]  out_rd;
    logic        out_divz;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_rd, flush, R, ZF, out_ready,
        output in_ready, A, B, SEL, out_valid, out_result, out_zf, out_rd, out_divz
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, in_rd, flush, R, ZF, out_ready,
        input  in_ready, A, B, SEL, out_valid, out_result, out_zf, out_rd, out_divz
    );

endinterface

// File: rtl/alu_issue.sv
// alu_issue: latches one op, holds it on the ALU for a multicycle window, then registers R/ZF for downstream
module alu_issue
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input logic       clk,
    input logic       rst,
    alu_issue_if.slave bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_load;
    logic [4:0]    rd;
    logic          take;
    logic          last;
    logic          divz;

    assign bus.in_ready  = !rst && !bus.flush && (state == IDLE || (state == DONE && bus.out_ready));
    assign bus.out_valid = (state == DONE);
    assign take          = bus.in_valid && bus.in_ready;
    assign last          = (state == EXEC) && (cnt == '0);
    assign divz          = (bus.SEL == ALU_DIV) && (bus.B == '0);
    // divide by zero gets a single EXEC cycle, so it loads 0 like a simple op
    assign cnt_load      = (bus.in_sel == ALU_MUL) ? CW'(MUL_CYCLES - 1) :
                           (bus.in_sel == ALU_DIV && bus.in_b != '0) ? CW'(DIV_CYCLES - 1) : '0;

    // next state: flush wins, then a new transfer, then EXEC completion, then retire
    always_comb begin
        state_n = state;
        state_n = bus.flush ? IDLE :
                  take ? EXEC :
                  last ? DONE :
                  (state == DONE && bus.out_ready) ? IDLE : state;
    end

    // state, held operands, window counter and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rd             <= '0;
            bus.A          <= '0;
            bus.B          <= '0;
            bus.SEL        <= '0;
            bus.out_result <= '0;
            bus.out_zf     <= 1'b0;
            bus.out_rd     <= '0;
            bus.out_divz   <= 1'b0;
        end else begin
            state <= state_n;
            if (take) begin
                bus.A   <= bus.in_a;
                bus.B   <= bus.in_b;
                bus.SEL <= bus.in_sel;
                rd      <= bus.in_rd;
                cnt     <= cnt_load;
            end else if (state == EXEC && cnt != '0 && !bus.flush) begin
                cnt <= cnt - 1'b1;
            end
            if (last && !bus.flush) begin
                bus.out_result <= divz ? 32'd0 : bus.R;
                bus.out_zf     <= divz ? 1'b1 : bus.ZF;
                bus.out_rd     <= rd;
                bus.out_divz   <= divz;
            end
        end
    end

endmodule
